vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the system clock. Drives the pixel coordinates `x`/`y` consumed by the shape-selection stage, and the `hsync`/`vsync`/`video_on` signals consumed by the colour/output stage. A pixel-enable divider runs the raster at `clk / CLK_DIV`. All outputs are registered and mutually aligned.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch (pixels); `H_TOTAL` = 800
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch (lines); `V_TOTAL` = 525
- `CLK_DIV`, 2: system clocks per pixel; legal range ≥1
- `clk` input 1: system clock; the single clock domain
- `reset` input 1: asynchronous, active-high reset
- `x` output 10: current horizontal count, 0..H_TOTAL-1
- `y` output 10: current vertical count, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, active low
- `vsync` output 1: vertical sync, active low
- `video_on` output 1: high when `x`<H_ACTIVE and `y`<V_ACTIVE
- `pix_tick` output 1: one-clk pulse on the first clk of each new pixel
- `frame_start` output 1: high for the whole pixel (0,0) of each frame

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. Internal advance `adv` = (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `adv` is constantly 1.
- On a clk edge with `adv` high:
  - `h_cnt` increments; at H_TOTAL-1 it wraps to 0.
  - On the h wrap, `v_cnt` increments; at V_TOTAL-1 it wraps to 0.
- `x`/`y` are the counter registers themselves.
- `hsync`, `vsync`, `video_on` and `frame_start` are registered on the same `adv` edge, decoded from the next counter values, so they stay aligned with `x`/`y`.
- `hsync` = 0 when `x` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751]; otherwise 1.
- `vsync` = 0 when `y` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491]; otherwise 1.
- `frame_start` = 1 when (`x`,`y`) = (0,0).
- `pix_tick` is registered from `adv`, so it is high during the first clk after each advance edge.
- Counter widths are 10 bits. All comparisons are unsigned. Parameter sums must be < 1024; this is checked by elaboration-time assertion.

## Timing
- Reset values (asynchronous, immediate):
  - `div_cnt`=0, `x`=H_TOTAL-1 (799), `y`=V_TOTAL-1 (524)
  - `hsync`=1, `vsync`=1, `video_on`=0, `pix_tick`=0, `frame_start`=0
- Reset preloads the last raster position, so the first advance lands on (0,0) with `frame_start`=1 and `video_on`=1.
- The first advance edge is the CLK_DIV-th rising `clk` edge after `reset` deasserts.
- Output latency is zero relative to the counters: every output changes on the same edge as `x`/`y`.
- Each pixel lasts CLK_DIV clks. A line lasts 800·CLK_DIV clks. A frame lasts 420000·CLK_DIV clks.
- Reset asserted mid-frame: all state returns to the reset values immediately. On release, restart as above. No partial-frame state is retained.
- The (799,524)→(0,0) advance wraps both counters on one edge and sets `frame_start`. `vsync` returns to 1 no later than that edge.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing localparams (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL)
  - derived sync start/end constants
  - the coordinate width constant (10)
- Sub-module `pixel_tick_gen` (parameter CLK_DIV; ports `clk`, `reset`, `adv`) contains the divider. The counters and the decode live in `vga_timing_gen`.

## Test plan
- **Reset:** hold `reset` high for 5 clks, then release. During reset, `x`=799, `y`=524, `hsync`=`vsync`=1, `video_on`=0. On the 2nd clk edge after release (CLK_DIV=2), `x`=0, `y`=0, `frame_start`=1, `video_on`=1, and `pix_tick`=1 on the following clk.
- **Horizontal:** over one line, `hsync` is low for exactly 96 pixels (192 clks), starting at `x`=656. `video_on` falls at `x`=640.
- **Vertical:** `vsync` is low only for `y`=490..491 (1600 pixels). `y` increments only on the `x`=799→0 edge.
- **Frame period:** successive `frame_start` rising edges are exactly 840000 clks apart at CLK_DIV=2.
- **Reset mid-frame:** assert `reset` at (`x`=300, `y`=200). Outputs return to the reset values asynchronously (checked before the next clk edge). The raster restarts at (0,0) CLK_DIV clks after release.
- **CLK_DIV=1:** `x` advances every clk, `pix_tick` stays constantly 1 after the first clk post-reset, and the frame period is 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz raster geometry shared by the VGA timing block.
package vga_timing_pkg;

    // Width of the x/y coordinate counters
    localparam int COORD_W = 10;

    // Horizontal timing in pixels
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulse windows, inclusive on both ends
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // System clocks per pixel
    localparam int CLK_DIV = 2;

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-enable divider: adv is high on the last system clock of every pixel.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic adv
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt_r;

    // With CLK_DIV of 1 the counter sits at zero and adv is permanently high
    assign adv = (div_cnt_r == DIV_LAST);

    // Divider counting 0..CLK_DIV-1 and wrapping on adv
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= DIV_ZERO;
        end else if (adv) begin
            div_cnt_r <= DIV_ZERO;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters plus sync/blank decode, all registered on
// the pixel-advance edge so every output moves together with x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic [vga_timing_pkg::COORD_W-1:0]  x,
    output logic [vga_timing_pkg::COORD_W-1:0]  y,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                video_on,
    output logic                                pix_tick,
    output logic                                frame_start
);

    localparam int CW       = vga_timing_pkg::COORD_W;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [CW-1:0] C_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_ACTIVE = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_V_ACTIVE = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_HS_START = CW'(HS_START);
    localparam logic [CW-1:0] C_HS_END   = CW'(HS_END);
    localparam logic [CW-1:0] C_VS_START = CW'(VS_START);
    localparam logic [CW-1:0] C_VS_END   = CW'(VS_END);

    // Every derived count must fit the 10-bit coordinate counters
    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_geometry
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be below 1024");
    end

    logic          adv_s;
    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic [CW-1:0] h_nxt_s;
    logic [CW-1:0] v_nxt_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;
    logic          video_on_nxt_s;
    logic          frame_start_nxt_s;
    logic          hsync_r;
    logic          vsync_r;
    logic          video_on_r;
    logic          frame_start_r;
    logic          pix_tick_r;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .adv   (adv_s)
    );

    // Next raster position: h wraps at end of line, v steps only on that wrap
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == C_H_LAST) begin
            h_nxt_s = C_ZERO;
            if (v_cnt_r == C_V_LAST) begin
                v_nxt_s = C_ZERO;
            end else begin
                v_nxt_s = v_cnt_r + C_ONE;
            end
        end else begin
            h_nxt_s = h_cnt_r + C_ONE;
        end
    end

    // Decode from the next position so the registered flags line up with x/y
    always_comb begin
        hsync_nxt_s       = ~((h_nxt_s >= C_HS_START) && (h_nxt_s <= C_HS_END));
        vsync_nxt_s       = ~((v_nxt_s >= C_VS_START) && (v_nxt_s <= C_VS_END));
        video_on_nxt_s    = (h_nxt_s < C_H_ACTIVE) && (v_nxt_s < C_V_ACTIVE);
        frame_start_nxt_s = (h_nxt_s == C_ZERO) && (v_nxt_s == C_ZERO);
    end

    // Raster counters and decoded flags; reset parks on the last position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_r       <= C_H_LAST;
            v_cnt_r       <= C_V_LAST;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (adv_s) begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            video_on_r    <= video_on_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    // One-clk strobe marking the first clock of each new pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_tick_r <= 1'b0;
        end else begin
            pix_tick_r <= adv_s;
        end
    end

    assign x           = h_cnt_r;
    assign y           = v_cnt_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign pix_tick    = pix_tick_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (two shrunk geometries at
// CLK_DIV 2 and 1, one at the default 640x480 geometry) share a clock and a
// randomly pulsed reset. A per-instance model turns "clocks since release"
// into a pixel index and pushes the expected outputs; a monitor pops them on
// every pix_tick and checks that outputs hold steady in between.
module tb_vga_timing_gen;

    localparam int N = 3;
    localparam int HA_A [N] = '{20, 20, 640};
    localparam int HF_A [N] = '{3, 3, 16};
    localparam int HS_A [N] = '{5, 5, 96};
    localparam int HB_A [N] = '{4, 4, 48};
    localparam int VA_A [N] = '{6, 6, 480};
    localparam int VF_A [N] = '{2, 2, 10};
    localparam int VS_A [N] = '{2, 2, 2};
    localparam int VB_A [N] = '{3, 3, 33};
    localparam int CD_A [N] = '{2, 1, 2};

    logic       clk;
    logic       rst;
    logic [9:0] xs [N];
    logic [9:0] ys [N];
    logic       hs [N];
    logic       vs [N];
    logic       vo [N];
    logic       tk [N];
    logic       fs [N];

    int      n_cmp;
    int      n_fail;
    longint  cyc;

    task automatic check(input string name, input int g,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int HA = HA_A[g];
        localparam int VA = VA_A[g];
        localparam int HSS = HA_A[g] + HF_A[g];
        localparam int VSS = VA_A[g] + VF_A[g];
        localparam int HT = HA_A[g] + HF_A[g] + HS_A[g] + HB_A[g];
        localparam int VT = VA_A[g] + VF_A[g] + VS_A[g] + VB_A[g];
        localparam int CD = CD_A[g];

        logic [23:0] q [$];

        if (g == 2) begin : g_def
            vga_timing_gen dut (
                .clk(clk), .reset(rst), .x(xs[g]), .y(ys[g]), .hsync(hs[g]),
                .vsync(vs[g]), .video_on(vo[g]), .pix_tick(tk[g]), .frame_start(fs[g])
            );
        end else begin : g_cfg
            vga_timing_gen #(
                .H_ACTIVE(HA_A[g]), .H_FP(HF_A[g]), .H_SYNC(HS_A[g]), .H_BP(HB_A[g]),
                .V_ACTIVE(VA_A[g]), .V_FP(VF_A[g]), .V_SYNC(VS_A[g]), .V_BP(VB_A[g]),
                .CLK_DIV(CD_A[g])
            ) dut (
                .clk(clk), .reset(rst), .x(xs[g]), .y(ys[g]), .hsync(hs[g]),
                .vsync(vs[g]), .video_on(vo[g]), .pix_tick(tk[g]), .frame_start(fs[g])
            );
        end

        // Expected {x, y, hsync, vsync, video_on, frame_start} for pixel p of a frame sequence
        function automatic logic [23:0] exp_of(input int unsigned p);
            int unsigned px;
            int unsigned py;
            px = p % HT;
            py = (p / HT) % VT;
            return {10'(px), 10'(py),
                    !((px >= HSS) && (px < HSS + HS_A[g])),
                    !((py >= VSS) && (py < VSS + VS_A[g])),
                    ((px < HA) && (py < VA)),
                    ((px == 0) && (py == 0))};
        endfunction

        // Reference model: every CD-th clock after release starts a new pixel
        initial begin : model
            int unsigned edges;
            edges = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    edges = 0;
                    q.delete();
                end else begin
                    edges++;
                    if (edges % CD == 0) q.push_back(exp_of(edges / CD - 1));
                end
            end
        end

        // Monitor: compare on each pix_tick, require stable outputs otherwise
        initial begin : monitor
            logic [23:0] last;
            logic [23:0] e;
            logic [23:0] act;
            logic [23:0] rst_v;
            bit          prev_fs;
            bit          have_rise;
            longint      last_rise;
            rst_v = {10'(HT - 1), 10'(VT - 1), 4'b1100};
            last = rst_v;
            prev_fs = 1'b0;
            have_rise = 1'b0;
            last_rise = 0;
            forever begin
                @(negedge clk);
                act = {xs[g], ys[g], hs[g], vs[g], vo[g], fs[g]};
                if (rst) begin
                    q.delete();
                    check("reset_state", g, 32'({act, tk[g]}), 32'({rst_v, 1'b0}));
                    last = rst_v;
                    prev_fs = 1'b0;
                    have_rise = 1'b0;
                end else begin
                    if (tk[g]) begin
                        if (q.size() == 0) begin
                            check("pix_tick_spurious", g, 32'(tk[g]), 32'(1'b0));
                        end else begin
                            e = q.pop_front();
                            check("pixel_outputs", g, 32'(act), 32'(e));
                            last = e;
                        end
                    end else begin
                        check("hold_between_ticks", g, 32'(act), 32'(last));
                        check("pix_tick_missing", g, 32'(q.size()), 32'(0));
                    end
                    if (fs[g] && !prev_fs) begin
                        if (have_rise) check("frame_period", g, 32'(cyc - last_rise), 32'(HT * VT * CD));
                        have_rise = 1'b1;
                        last_rise = cyc;
                    end
                    prev_fs = fs[g];
                end
            end
        end
    end

    // Reset values must appear asynchronously, before any clock edge
    task automatic check_async_reset();
        for (int i = 0; i < N; i++) begin
            check("async_reset", i,
                  32'({xs[i], ys[i], hs[i], vs[i], vo[i], fs[i], tk[i]}),
                  32'({10'(HA_A[i] + HF_A[i] + HS_A[i] + HB_A[i] - 1),
                       10'(VA_A[i] + VF_A[i] + VS_A[i] + VB_A[i] - 1), 5'b11000}));
        end
    endtask

    // Stimulus: initial reset, then runs of random length cut by random mid-frame resets
    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_async_reset();
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        repeat (4000) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #3 rst = 1'b1;
            #1 check_async_reset();
            repeat ($urandom_range(5, 1)) @(posedge clk);
            #3 rst = 1'b0;
            repeat ($urandom_range(9000, 1500)) @(posedge clk);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
